// File: rtl/microc_stack_if.sv
// Bus bundle for microc_stack: instruction fetch, control inputs and status outputs.
// Define MICROC_STACK_CARRY_EN to add the carry flag signal c.
interface microc_stack_if #(
    parameter int PC_W = 10
);
    logic [15:0]     instr;
    logic [PC_W-1:0] pc;
    logic [5:0]      Opcode;
    logic            s_inc;
    logic            s_inm;
    logic            we3;
    logic            wez;
    logic [2:0]      Op;
    logic            push;
    logic            pop;
    logic            z;
    logic            stack_full;
    logic            stack_empty;
    logic            stack_err;
`ifdef MICROC_STACK_CARRY_EN
    logic            c;
`endif

    modport slave (
        input  instr, s_inc, s_inm, we3, wez, Op, push, pop,
        output pc, Opcode, z, stack_full, stack_empty, stack_err
`ifdef MICROC_STACK_CARRY_EN
        , output c
`endif
    );

    modport master (
        output instr, s_inc, s_inm, we3, wez, Op, push, pop,
        input  pc, Opcode, z, stack_full, stack_empty, stack_err
`ifdef MICROC_STACK_CARRY_EN
        , input c
`endif
    );
endinterface

// File: rtl/microc_stack.sv
// Single-cycle microcontroller datapath with register file, ALU and return-address stack.
// Define MICROC_STACK_CARRY_EN to add a registered carry/borrow flag on bus.c.
module microc_stack #(
    parameter int DATA_W      = 8,
    parameter int PC_W        = 10,
    parameter int STACK_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    microc_stack_if.slave bus
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W   = $clog2(STACK_DEPTH);

    logic [PC_W-1:0]    r_pc;
    logic               r_z;
    logic [DEPTH_W-1:0] r_depth;
    logic               r_err;
    logic [PC_W-1:0]    r_stack [STACK_DEPTH];
    logic [DATA_W-1:0]  r_regs  [16];

    logic [3:0]         w_ra1, w_ra2, w_wa3;
    logic [DATA_W-1:0]  w_rd1, w_rd2, w_sum, w_alu, w_wd3;
    logic [PC_W-1:0]    w_pcInc, w_seqPc, w_nextPc, w_top;
    logic [IDX_W-1:0]   w_wrIdx, w_topIdx;
    logic [DEPTH_W-1:0] w_nextDepth;
    logic               w_full, w_empty, w_stackWe, w_setErr;

    assign w_ra1 = bus.instr[11:8];
    assign w_ra2 = bus.instr[7:4];
    assign w_wa3 = bus.instr[3:0];

    // r0 is never written, so its reads are forced to zero here.
    assign w_rd1 = (w_ra1 == 4'd0) ? '0 : r_regs[w_ra1];
    assign w_rd2 = (w_ra2 == 4'd0) ? '0 : r_regs[w_ra2];

`ifdef MICROC_STACK_CARRY_EN
    logic w_carry;
    logic r_c;
    assign {w_carry, w_sum} = {1'b0, w_rd1} + {1'b0, w_rd2};
`else
    assign w_sum = w_rd1 + w_rd2;
`endif

    always_comb begin
        w_alu = '0;
        case (bus.Op)
            3'b000:  w_alu = w_rd1;
            3'b001:  w_alu = ~w_rd1;
            3'b010:  w_alu = w_sum;
            3'b011:  w_alu = w_rd1 - w_rd2;
            3'b100:  w_alu = w_rd1 & w_rd2;
            3'b101:  w_alu = w_rd1 | w_rd2;
            3'b110:  w_alu = -w_rd1;
            default: w_alu = -w_rd2;
        endcase
    end

    assign w_wd3 = bus.s_inm ? DATA_W'(bus.instr[11:4]) : w_alu;

    assign w_full   = (r_depth == DEPTH_W'(STACK_DEPTH));
    assign w_empty  = (r_depth == '0);
    assign w_wrIdx  = IDX_W'(r_depth);
    assign w_topIdx = IDX_W'(r_depth - 1'b1);
    assign w_top    = r_stack[w_topIdx];

    assign w_pcInc = r_pc + 1'b1;
    assign w_seqPc = bus.s_inc ? w_pcInc : bus.instr[PC_W-1:0];

    // Stack arbitration: conflict beats pop beats push; errors never move the stack.
    always_comb begin
        w_nextPc    = w_seqPc;
        w_nextDepth = r_depth;
        w_stackWe   = 1'b0;
        w_setErr    = 1'b0;
        if (bus.push && bus.pop) begin
            w_setErr = 1'b1;
        end else if (bus.pop) begin
            if (!w_empty) begin
                w_nextPc    = w_top;
                w_nextDepth = r_depth - 1'b1;
            end else begin
                w_nextPc = '0;
                w_setErr = 1'b1;
            end
        end else if (bus.push) begin
            if (!w_full) begin
                w_stackWe   = 1'b1;
                w_nextDepth = r_depth + 1'b1;
            end else begin
                w_setErr = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= '0;
            r_z     <= 1'b0;
            r_depth <= '0;
            r_err   <= 1'b0;
        end else begin
            r_pc    <= w_nextPc;
            r_depth <= w_nextDepth;
            if (w_setErr) r_err <= 1'b1;
            if (bus.wez)  r_z   <= (w_alu == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && bus.we3 && (w_wa3 != 4'd0)) r_regs[w_wa3] <= w_wd3;
    end

    always_ff @(posedge clk) begin
        if (!reset && w_stackWe) r_stack[w_wrIdx] <= w_pcInc;
    end

`ifdef MICROC_STACK_CARRY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_c <= 1'b0;
        end else if (bus.wez) begin
            case (bus.Op)
                3'b010:  r_c <= w_carry;
                3'b011:  r_c <= (w_rd1 < w_rd2);
                default: r_c <= 1'b0;
            endcase
        end
    end
    assign bus.c = r_c;
`endif

    assign bus.pc          = r_pc;
    assign bus.Opcode      = bus.instr[15:10];
    assign bus.z           = r_z;
    assign bus.stack_full  = w_full;
    assign bus.stack_empty = w_empty;
    assign bus.stack_err   = r_err;
endmodule

// File: tb/tb_microc_stack.sv
// Self-checking bench for microc_stack: directed vector table then randomized run against a queue-based model.
module tb_microc_stack;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;
    int   passCount;
    int   checkCount;

    microc_stack_if #(.PC_W(10)) bus ();

    microc_stack #(.DATA_W(8), .PC_W(10), .STACK_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [15:0] instr;
        logic        sInc, sInm, we3, wez;
        logic [2:0]  op;
        logic        push, pop;
        int          ePc;
        logic        eZ, eC, eEmpty, eFull, eErr;
    } stim_t;

    // Reference model state: plain ints and a queue for the return stack.
    int mPc, mRegs[16], mStack[$];
    logic mZ, mC, mErr;

    function automatic stim_t mk(logic rst, logic [15:0] instr, logic sInc, logic sInm,
                                 logic we3, logic wez, logic [2:0] op, logic push, logic pop,
                                 int ePc, logic eZ, logic eC, logic eEmpty, logic eFull, logic eErr);
        stim_t s;
        s.rst = rst; s.instr = instr; s.sInc = sInc; s.sInm = sInm; s.we3 = we3; s.wez = wez;
        s.op = op; s.push = push; s.pop = pop; s.ePc = ePc; s.eZ = eZ; s.eC = eC;
        s.eEmpty = eEmpty; s.eFull = eFull; s.eErr = eErr;
        return s;
    endfunction

    task automatic checkVal(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input stim_t s);
        reset      = s.rst;
        bus.instr  = s.instr;
        bus.s_inc  = s.sInc;
        bus.s_inm  = s.sInm;
        bus.we3    = s.we3;
        bus.wez    = s.wez;
        bus.Op     = s.op;
        bus.push   = s.push;
        bus.pop    = s.pop;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int ePc, input logic eZ, input logic eC,
                               input logic eEmpty, input logic eFull, input logic eErr);
        checkVal({tag, ".pc"}, int'(bus.pc), ePc);
        checkVal({tag, ".z"}, int'(bus.z), int'(eZ));
        checkVal({tag, ".empty"}, int'(bus.stack_empty), int'(eEmpty));
        checkVal({tag, ".full"}, int'(bus.stack_full), int'(eFull));
        checkVal({tag, ".err"}, int'(bus.stack_err), int'(eErr));
`ifdef MICROC_STACK_CARRY_EN
        checkVal({tag, ".c"}, int'(bus.c), int'(eC));
`else
        if (eC === 1'bx) $display("[TB] unexpected X carry expectation in %s", tag);
`endif
    endtask

    // Applies the architectural rules to the model for one clock edge.
    task automatic modelStep(input stim_t s);
        int a, b, res, wd, nextPc;
        if (s.rst) begin
            mPc = 0; mZ = 0; mC = 0; mErr = 0;
            mStack.delete();
            return;
        end
        a = mRegs[s.instr[11:8]];
        b = mRegs[s.instr[7:4]];
        case (s.op)
            3'd0: res = a;
            3'd1: res = 255 - a;
            3'd2: res = a + b;
            3'd3: res = a - b;
            3'd4: res = a & b;
            3'd5: res = a | b;
            3'd6: res = -a;
            default: res = -b;
        endcase
        res = res & 255;
        wd = s.sInm ? int'(s.instr[11:4]) : res;
        nextPc = s.sInc ? (mPc + 1) % 1024 : int'(s.instr[9:0]);
        if (s.push && s.pop) mErr = 1;
        else if (s.pop) begin
            if (mStack.size() > 0) nextPc = mStack.pop_back();
            else begin nextPc = 0; mErr = 1; end
        end else if (s.push) begin
            if (mStack.size() < DEPTH) mStack.push_back((mPc + 1) % 1024);
            else mErr = 1;
        end
        if (s.we3 && s.instr[3:0] != 4'd0) mRegs[s.instr[3:0]] = wd;
        if (s.wez) begin
            mZ = (res == 0);
            mC = (s.op == 3'd2) ? ((a + b) > 255) : (s.op == 3'd3) ? (a < b) : 1'b0;
        end
        mPc = nextPc;
    endtask

    stim_t vecs[34];

    initial begin
        stim_t s;
        passCount = 0;
        checkCount = 0;
        foreach (mRegs[i]) mRegs[i] = 0;

        //              rst instr    inc inm we3 wez op  psh pop  pc     z  c  emp ful err
        vecs[0]  = mk(1, 16'h0000, 0, 0, 0, 0, 3'd0, 0, 0, 'h000, 0, 0, 1, 0, 0);
        vecs[1]  = mk(0, 16'h05A3, 1, 1, 1, 0, 3'd0, 0, 0, 'h001, 0, 0, 1, 0, 0);
        vecs[2]  = mk(0, 16'h0300, 1, 0, 0, 1, 3'd0, 0, 0, 'h002, 0, 0, 1, 0, 0);
        vecs[3]  = mk(0, 16'h0A64, 1, 1, 1, 0, 3'd0, 0, 0, 'h003, 0, 0, 1, 0, 0);
        vecs[4]  = mk(0, 16'h0345, 1, 0, 1, 1, 3'd2, 0, 0, 'h004, 1, 1, 1, 0, 0);
        vecs[5]  = mk(0, 16'h0500, 1, 0, 0, 1, 3'd0, 0, 0, 'h005, 1, 0, 1, 0, 0);
        vecs[6]  = mk(0, 16'h0FF0, 1, 1, 1, 0, 3'd0, 0, 0, 'h006, 1, 0, 1, 0, 0);
        vecs[7]  = mk(0, 16'h0000, 1, 0, 0, 1, 3'd0, 0, 0, 'h007, 1, 0, 1, 0, 0);
        vecs[8]  = mk(0, 16'h0340, 1, 0, 0, 1, 3'd3, 0, 0, 'h008, 0, 1, 1, 0, 0);
        vecs[9]  = mk(0, 16'h0005, 0, 0, 0, 0, 3'd0, 0, 0, 'h005, 0, 1, 1, 0, 0);
        vecs[10] = mk(0, 16'h0100, 0, 0, 0, 0, 3'd0, 1, 0, 'h100, 0, 1, 0, 0, 0);
        vecs[11] = mk(0, 16'h0000, 1, 0, 0, 0, 3'd0, 0, 1, 'h006, 0, 1, 1, 0, 0);
        vecs[12] = mk(0, 16'h0001, 0, 0, 0, 0, 3'd0, 0, 0, 'h001, 0, 1, 1, 0, 0);
        vecs[13] = mk(0, 16'h0002, 0, 0, 0, 0, 3'd0, 1, 0, 'h002, 0, 1, 0, 0, 0);
        vecs[14] = mk(0, 16'h0003, 0, 0, 0, 0, 3'd0, 1, 0, 'h003, 0, 1, 0, 0, 0);
        vecs[15] = mk(0, 16'h0004, 0, 0, 0, 0, 3'd0, 1, 0, 'h004, 0, 1, 0, 0, 0);
        vecs[16] = mk(0, 16'h0010, 0, 0, 0, 0, 3'd0, 1, 0, 'h010, 0, 1, 0, 1, 0);
        vecs[17] = mk(0, 16'h0020, 0, 0, 0, 0, 3'd0, 1, 0, 'h020, 0, 1, 0, 1, 1);
        vecs[18] = mk(0, 16'h0000, 1, 0, 0, 0, 3'd0, 0, 1, 'h005, 0, 1, 0, 0, 1);
        vecs[19] = mk(0, 16'h0000, 1, 0, 0, 0, 3'd0, 0, 1, 'h004, 0, 1, 0, 0, 1);
        vecs[20] = mk(0, 16'h0000, 1, 0, 0, 0, 3'd0, 0, 1, 'h003, 0, 1, 0, 0, 1);
        vecs[21] = mk(0, 16'h0000, 1, 0, 0, 0, 3'd0, 0, 1, 'h002, 0, 1, 1, 0, 1);
        vecs[22] = mk(0, 16'h0037, 0, 0, 0, 0, 3'd0, 0, 0, 'h037, 0, 1, 1, 0, 1);
        vecs[23] = mk(0, 16'h0000, 1, 0, 0, 0, 3'd0, 0, 1, 'h000, 0, 1, 1, 0, 1);
        vecs[24] = mk(1, 16'h0000, 1, 0, 0, 0, 3'd0, 0, 0, 'h000, 0, 0, 1, 0, 0);
        vecs[25] = mk(0, 16'h0008, 0, 0, 0, 0, 3'd0, 0, 0, 'h008, 0, 0, 1, 0, 0);
        vecs[26] = mk(0, 16'h0000, 1, 0, 0, 0, 3'd0, 1, 1, 'h009, 0, 0, 1, 0, 1);
        vecs[27] = mk(0, 16'h0020, 0, 0, 0, 1, 3'd0, 0, 0, 'h020, 1, 0, 1, 0, 1);
        vecs[28] = mk(1, 16'h0100, 0, 0, 0, 0, 3'd0, 1, 0, 'h000, 0, 0, 1, 0, 0);
        vecs[29] = mk(0, 16'h0000, 1, 0, 0, 0, 3'd0, 0, 1, 'h000, 0, 0, 1, 0, 1);
        vecs[30] = mk(0, 16'h03FF, 0, 0, 0, 0, 3'd0, 0, 0, 'h3FF, 0, 0, 1, 0, 1);
        vecs[31] = mk(0, 16'h0050, 0, 0, 0, 0, 3'd0, 1, 0, 'h050, 0, 0, 0, 0, 1);
        vecs[32] = mk(0, 16'h0000, 1, 0, 0, 0, 3'd0, 0, 1, 'h000, 0, 0, 1, 0, 1);
        vecs[33] = mk(0, 16'h0000, 1, 0, 0, 0, 3'd0, 0, 0, 'h001, 0, 0, 1, 0, 1);

        for (int i = 0; i < 34; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), vecs[i].ePc, vecs[i].eZ, vecs[i].eC,
                        vecs[i].eEmpty, vecs[i].eFull, vecs[i].eErr);
        end

        // Randomized phase: reset, give every register a known value, then random traffic.
        s = mk(1, 16'h0000, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        modelStep(s);
        applyStimulus(s);
        for (int r = 1; r < 16; r++) begin
            s = mk(0, {4'h0, 8'($urandom_range(0, 255)), 4'(r)}, 1, 1, 1, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
            modelStep(s);
            applyStimulus(s);
        end
        checkOutput("init", mPc, mZ, mC, mStack.size() == 0, mStack.size() == DEPTH, mErr);

        for (int n = 0; n < 400; n++) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            s.rst   = ($urandom_range(0, 99) < 2);
            s.instr = 16'($urandom);
            s.sInc  = 1'($urandom);
            s.sInm  = ($urandom_range(0, 3) == 0);
            s.we3   = 1'($urandom);
            s.wez   = 1'($urandom);
            s.op    = 3'($urandom);
            s.push  = (sel < 25) || (sel >= 95);
            s.pop   = (sel >= 25 && sel < 50) || (sel >= 95);
            bus.instr = s.instr;
            #1;
            checkVal($sformatf("rnd%0d.Opcode", n), int'(bus.Opcode), int'(s.instr[15:10]));
            modelStep(s);
            applyStimulus(s);
            checkOutput($sformatf("rnd%0d", n), mPc, mZ, mC, mStack.size() == 0,
                        mStack.size() == DEPTH, mErr);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
